// File: rtl/alarm_store_if.sv
// Read-select port between the alarm matcher and the 4-slot alarm store.
// The matcher drives the slot select; the store answers one cycle later.
interface alarm_store_if;
   logic [1:0] alm_sel;
   logic [3:0] alm_mq0;
   logic [2:0] alm_mq1;
   logic [3:0] alm_hq0;
   logic [1:0] alm_hq1;
   logic [3:0] alm_en;
   logic       set_active;

   modport master (
      output alm_sel,
      input  alm_mq0, alm_mq1, alm_hq0, alm_hq1,
      input  alm_en, set_active
   );

   modport slave (
      input  alm_sel,
      output alm_mq0, alm_mq1, alm_hq0, alm_hq1,
      output alm_en, set_active
   );
endinterface

// File: rtl/alarm_matcher.sv
// Alarm matcher: scans the 4 stored slots on every minute change and
// rings on a match, with acknowledge, snooze and ring-timeout handling.
module alarm_matcher #(
   parameter int unsigned RING_SECS  = 60,
   parameter int unsigned SNOOZE_MIN = 5
) (
   input  logic       clk,
   input  logic       clr,
   input  logic       sec_tick,
   input  logic [3:0] cur_mq0,
   input  logic [2:0] cur_mq1,
   input  logic [3:0] cur_hq0,
   input  logic [1:0] cur_hq1,
   input  logic       ack,
   input  logic       snooze,
   alarm_store_if.master st,
   output logic       ring,
   output logic [1:0] ring_slot,
   output logic       snoozing,
   output logic       missed
);

   typedef enum logic [1:0] {IDLE, SCAN, RING, SNOOZE} state_e;

   localparam logic [8:0] RS = 9'(RING_SECS);
   localparam logic [4:0] SM = 5'(SNOOZE_MIN);

   state_e      state_q, state_d;
   logic [12:0] prev_q;
   logic        init_q;
   logic        sa_q;
   logic [12:0] cap_q, cap_d;
   logic        pend_q, pend_d;
   logic [2:0]  stage_q, stage_d;
   logic [1:0]  sel_q, sel_d;
   logic        found_q, found_d;
   logic [1:0]  hit_q, hit_d;
   logic [1:0]  slot_q, slot_d;
   logic [7:0]  sec_q, sec_d;
   logic [3:0]  snz_q, snz_d;
   logic        missed_q, missed_d;

   logic [12:0] cur_w;
   logic [12:0] rd_w;
   logic        chg;
   logic        fall;
   logic [1:0]  rd_idx;
   logic        hit_w;
   logic [8:0]  sec_sum;
   logic [4:0]  snz_sum;

   assign cur_w   = {cur_hq1, cur_hq0, cur_mq1, cur_mq0};
   assign rd_w    = {st.alm_hq1, st.alm_hq0, st.alm_mq1, st.alm_mq0};
   assign chg     = init_q && (cur_w != prev_q);
   assign fall    = sa_q && !st.set_active;
   assign rd_idx  = stage_q[1:0] - 2'd1;
   assign hit_w   = (stage_q != 3'd0) && (rd_w == cap_q)
                 && st.alm_en[rd_idx];
   assign sec_sum = {1'b0, sec_q} + {8'd0, sec_tick};
   assign snz_sum = {1'b0, snz_q} + {4'd0, chg};

   assign st.alm_sel = sel_q;
   assign ring       = (state_q == RING);
   assign snoozing   = (state_q == SNOOZE);
   assign ring_slot  = slot_q;
   assign missed     = missed_q;

   // Next state: scan pipeline, ring timeout, snooze count, key handling.
   always_comb begin
      state_d  = state_q;
      cap_d    = cap_q;
      pend_d   = pend_q & ~chg;
      stage_d  = stage_q;
      sel_d    = sel_q;
      found_d  = found_q;
      hit_d    = hit_q;
      slot_d   = slot_q;
      sec_d    = sec_q;
      snz_d    = snz_q;
      missed_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if ((chg && !st.set_active) || (!chg && fall && pend_q)) begin
               state_d = SCAN;
               cap_d   = chg ? cur_w : cap_q;
               pend_d  = 1'b0;
               stage_d = 3'd0;
               sel_d   = 2'd0;
               found_d = 1'b0;
            end
         end
         SCAN: begin
            if (st.set_active) begin
               // edit in progress: read data is not trustworthy
               state_d = IDLE;
               pend_d  = !chg;
               sel_d   = 2'd0;
            end else begin
               if (hit_w && !found_q) begin
                  found_d = 1'b1;
                  hit_d   = rd_idx;
               end
               if (stage_q == 3'd4) begin
                  sel_d = 2'd0;
                  if (found_q || hit_w) begin
                     state_d = RING;
                     slot_d  = found_q ? hit_q : rd_idx;
                     sec_d   = 8'd0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  stage_d = stage_q + 3'd1;
                  sel_d   = (stage_q == 3'd3) ? 2'd3
                          : stage_q[1:0] + 2'd1;
               end
            end
         end
         RING: begin
            if (ack) begin
               state_d = IDLE;
               slot_d  = 2'd0;
            end else if (snooze) begin
               state_d = SNOOZE;
               snz_d   = 4'd0;
            end else if (sec_sum == RS) begin
               state_d  = IDLE;
               slot_d   = 2'd0;
               missed_d = 1'b1;
            end else begin
               sec_d = sec_sum[7:0];
            end
         end
         SNOOZE: begin
            if (ack) begin
               state_d = IDLE;
               slot_d  = 2'd0;
            end else if (snz_sum == SM) begin
               state_d = RING;
               sec_d   = 8'd0;
            end else begin
               snz_d = snz_sum[3:0];
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers; prev minute tracks cur every cycle after reset.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         prev_q   <= 13'd0;
         init_q   <= 1'b0;
         sa_q     <= 1'b0;
         cap_q    <= 13'd0;
         pend_q   <= 1'b0;
         stage_q  <= 3'd0;
         sel_q    <= 2'd0;
         found_q  <= 1'b0;
         hit_q    <= 2'd0;
         slot_q   <= 2'd0;
         sec_q    <= 8'd0;
         snz_q    <= 4'd0;
         missed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= cur_w;
         init_q   <= 1'b1;
         sa_q     <= st.set_active;
         cap_q    <= cap_d;
         pend_q   <= pend_d;
         stage_q  <= stage_d;
         sel_q    <= sel_d;
         found_q  <= found_d;
         hit_q    <= hit_d;
         slot_q   <= slot_d;
         sec_q    <= sec_d;
         snz_q    <= snz_d;
         missed_q <= missed_d;
      end
   end

endmodule

// File: tb/tb_alarm_matcher.sv
// Bench for alarm_matcher: directed scenarios with literal expectations
// plus randomized traffic compared against a behavioural model.
module tb_alarm_matcher;

   localparam int RS = 3;
   localparam int SM = 2;

   logic       clk = 0;
   logic       clr = 0;
   logic       sec_tick = 0;
   logic [3:0] cur_mq0 = 0;
   logic [2:0] cur_mq1 = 0;
   logic [3:0] cur_hq0 = 0;
   logic [1:0] cur_hq1 = 0;
   logic       ack = 0;
   logic       snooze = 0;
   logic       ring;
   logic [1:0] ring_slot;
   logic       snoozing;
   logic       missed;

   logic        sa = 0;
   logic [3:0]  en = 0;
   logic [12:0] slot [4];

   int n_vec = 0;
   int n_bad = 0;

   alarm_store_if sif ();

   assign sif.alm_en     = en;
   assign sif.set_active = sa;

   // store with one-cycle registered read
   always @(posedge clk)
      {sif.alm_hq1, sif.alm_hq0, sif.alm_mq1, sif.alm_mq0} <= slot[sif.alm_sel];

   alarm_matcher #(.RING_SECS(RS), .SNOOZE_MIN(SM)) dut (
      .clk(clk), .clr(clr), .sec_tick(sec_tick),
      .cur_mq0(cur_mq0), .cur_mq1(cur_mq1),
      .cur_hq0(cur_hq0), .cur_hq1(cur_hq1),
      .ack(ack), .snooze(snooze), .st(sif.master),
      .ring(ring), .ring_slot(ring_slot),
      .snoozing(snoozing), .missed(missed)
   );

   always #5 clk = ~clk;

   function automatic logic [12:0] mk(int h, int m);
      return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
   endfunction

   function automatic logic [12:0] curv();
      return {cur_hq1, cur_hq0, cur_mq1, cur_mq0};
   endfunction

   task automatic set_cur(int h, int m);
      {cur_hq1, cur_hq0, cur_mq1, cur_mq0} = mk(h, m);
   endtask

   task automatic chk(string n, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // modes: 0 idle, 1 scanning, 2 ringing, 3 snoozed
   int          m_mode, m_age, m_target, m_slot, m_secs, m_snz;
   bit          m_init, m_pend, m_sa, m_missed;
   logic [12:0] m_prev, m_cap;

   function automatic int lowest(logic [12:0] v);
      for (int i = 0; i < 4; i++)
         if (en[i] && slot[i] == v) return i;
      return -1;
   endfunction

   always @(posedge clk or negedge clr) begin
      logic [12:0] c;
      bit chg, fall, pn;
      if (!clr) begin
         m_mode = 0; m_age = 0; m_target = -1; m_slot = 0;
         m_secs = 0; m_snz = 0; m_init = 0; m_pend = 0;
         m_sa = 0; m_missed = 0; m_prev = 0; m_cap = 0;
      end else begin
         c = curv();
         chg = m_init && (c != m_prev);
         fall = m_sa && !sa;
         pn = m_pend && !chg;
         m_missed = 0;
         case (m_mode)
            0: if (chg && !sa) begin
                  m_mode = 1; m_age = 0; m_cap = c;
                  m_target = lowest(c); pn = 0;
               end else if (!chg && fall && m_pend) begin
                  m_mode = 1; m_age = 0;
                  m_target = lowest(m_cap); pn = 0;
               end
            1: if (sa) begin
                  m_mode = 0; pn = !chg;
               end else if (m_age == 4) begin
                  if (m_target >= 0) begin
                     m_mode = 2; m_slot = m_target; m_secs = 0;
                  end else m_mode = 0;
               end else m_age++;
            2: if (ack) begin
                  m_mode = 0; m_slot = 0;
               end else if (snooze) begin
                  m_mode = 3; m_snz = 0;
               end else if (m_secs + int'(sec_tick) == RS) begin
                  m_mode = 0; m_slot = 0; m_missed = 1;
               end else m_secs += int'(sec_tick);
            default: if (ack) begin
                  m_mode = 0; m_slot = 0;
               end else if (m_snz + int'(chg) == SM) begin
                  m_mode = 2; m_secs = 0;
               end else m_snz += int'(chg);
         endcase
         m_pend = pn;
         m_prev = c;
         m_init = 1;
         m_sa = sa;
      end
   end

   // every cycle: DUT outputs against the model
   always @(negedge clk) begin
      chk("m_ring", int'(ring), int'(m_mode == 2));
      chk("m_snoozing", int'(snoozing), int'(m_mode == 3));
      chk("m_ring_slot", int'(ring_slot), m_slot);
      chk("m_missed", int'(missed), int'(m_missed));
      chk("m_alm_sel", int'(sif.alm_sel),
          (m_mode == 1) ? ((m_age > 3) ? 3 : m_age) : 0);
   end

   task automatic waitn(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_tick();
      sec_tick = 1; @(negedge clk); sec_tick = 0;
   endtask

   task automatic pulse_ack();
      ack = 1; @(negedge clk); ack = 0;
   endtask

   task automatic ring_up();
      set_cur(7, 31); waitn(8);
      set_cur(7, 30); waitn(7);
   endtask

   function automatic logic [12:0] pool(int k);
      case (k)
         0: return mk(7, 30);
         1: return mk(7, 31);
         2: return mk(12, 0);
         3: return mk(23, 59);
         default: return curv();
      endcase
   endfunction

   initial begin
      int sa_left;
      logic [12:0] t;
      slot[0] = mk(12, 0); slot[1] = mk(12, 0);
      slot[2] = mk(7, 30); slot[3] = mk(12, 0);
      en = 4'b0100;
      set_cur(7, 29);
      waitn(3);
      chk("rst ring", ring, 0);
      chk("rst sel", sif.alm_sel, 0);
      chk("rst slot", ring_slot, 0);
      chk("rst snoozing", snoozing, 0);
      chk("rst missed", missed, 0);
      clr = 1;
      waitn(3);
      chk("post-rst ring", ring, 0);

      // T1: single armed slot, select sequence and ring latency
      set_cur(7, 30);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("T1 sel", sif.alm_sel, k);
      end
      @(negedge clk);
      chk("T1 S4 ring", ring, 0);
      @(negedge clk);
      chk("T1 ring", ring, 1);
      chk("T1 slot", ring_slot, 2);
      pulse_ack();
      chk("T1 ack ring", ring, 0);
      chk("T1 ack slot", ring_slot, 0);

      // T2: lowest matching index; disarmed mask never rings
      slot[1] = mk(7, 30); slot[2] = mk(12, 0); slot[3] = mk(7, 30);
      en = 4'b1010;
      set_cur(7, 31); waitn(8);
      set_cur(7, 30); waitn(6);
      chk("T2 ring", ring, 1);
      chk("T2 slot", ring_slot, 1);
      pulse_ack();
      en = 4'b0000;
      set_cur(7, 31); waitn(8);
      set_cur(7, 30); waitn(8);
      chk("T2 off ring", ring, 0);
      chk("T2 off sel", sif.alm_sel, 0);

      // T3: timeout after RS ticks, then ack before timeout
      en = 4'b1010;
      ring_up();
      chk("T3 ring", ring, 1);
      pulse_tick(); chk("T3 t1 ring", ring, 1);
      pulse_tick(); chk("T3 t2 missed", missed, 0);
      pulse_tick();
      chk("T3 t3 missed", missed, 1);
      chk("T3 t3 ring", ring, 0);
      @(negedge clk);
      chk("T3 missed pulse", missed, 0);
      ring_up();
      pulse_tick();
      pulse_ack();
      chk("T3b ring", ring, 0);
      for (int k = 0; k < 3; k++) begin
         pulse_tick();
         chk("T3b missed", missed, 0);
      end

      // T4: snooze, re-ring after SM minute changes, ack beats snooze
      ring_up();
      snooze = 1; @(negedge clk); snooze = 0;
      chk("T4 snoozing", snoozing, 1);
      chk("T4 ring", ring, 0);
      chk("T4 slot", ring_slot, 1);
      set_cur(7, 31); @(negedge clk);
      chk("T4 one min", snoozing, 1);
      set_cur(7, 32); @(negedge clk);
      chk("T4 rering", ring, 1);
      chk("T4 rering slot", ring_slot, 1);
      ack = 1; snooze = 1; @(negedge clk); ack = 0; snooze = 0;
      chk("T4 both ring", ring, 0);
      chk("T4 both snz", snoozing, 0);

      // T5: edit aborts scan; rescan on release if minute unchanged
      set_cur(7, 30); waitn(3);
      sa = 1; waitn(10); sa = 0;
      waitn(8);
      chk("T5 rescan ring", ring, 1);
      chk("T5 rescan slot", ring_slot, 1);
      pulse_ack();
      set_cur(7, 31); waitn(8);
      set_cur(7, 30); waitn(3);
      sa = 1; waitn(3);
      set_cur(7, 31); waitn(7);
      sa = 0; waitn(10);
      chk("T5 moved ring", ring, 0);
      chk("T5 moved sel", sif.alm_sel, 0);

      // T6: asynchronous reset mid-ring
      ring_up();
      chk("T6 ring", ring, 1);
      #2 clr = 0;
      #1;
      chk("T6 async ring", ring, 0);
      chk("T6 async slot", ring_slot, 0);
      chk("T6 async sel", sif.alm_sel, 0);
      @(negedge clk);
      set_cur(7, 30);
      @(negedge clk);
      clr = 1;
      waitn(10);
      chk("T6 no power-up ring", ring, 0);
      set_cur(7, 31); waitn(8);
      chk("T6 other min", ring, 0);
      set_cur(7, 30); waitn(7);
      chk("T6 next match", ring, 1);
      pulse_ack();

      // randomized traffic, model-checked every cycle
      sa_left = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         sec_tick = ($urandom % 4) == 0;
         ack = ($urandom % 50) == 0;
         snooze = ($urandom % 30) == 0;
         if (($urandom % 25) == 0) begin
            if ($urandom % 2 == 1) t = slot[$urandom % 4];
            else t = mk($urandom % 24, $urandom % 60);
            {cur_hq1, cur_hq0, cur_mq1, cur_mq0} = t;
         end
         if (sa_left > 0) begin
            sa_left--;
            if (sa_left == 0) sa = 0;
            else if (($urandom % 3) == 0) begin
               slot[$urandom % 4] = pool($urandom % 5);
               en = 4'($urandom);
            end
         end else if (($urandom % 80) == 0) begin
            sa = 1;
            sa_left = $urandom_range(2, 15);
         end
      end
      sa = 0; ack = 0; snooze = 0; sec_tick = 0;
      waitn(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
